serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/adder_pkg.sv | 12 +
 rtl/serial_adder_full_adder.sv | 55 +++++
 rtl/serial_adder.sv | 140 ++++++++++++++
 tb/tb_serial_adder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg -- shared definitions for the serial adder.
// Holds the controller state encoding so the top level and any
// observers agree on what each state value means.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// half_adder / full_adder -- one-bit adder cells used as the per-cycle
// slice adder of serial_adder.
//
// half_adder ports:
//   a_i, b_i : addend bits
//   s_o      : sum bit
//   c_o      : carry out
//
// full_adder ports:
//   a_i, b_i : addend bits
//   c_i      : carry in
//   s_o      : sum bit
//   c_o      : carry out
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic s_ab;
  logic c_ab;
  logic c_abc;

  half_adder u_ha_ab (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (s_ab),
    .c_o (c_ab)
  );

  half_adder u_ha_sc (
    .a_i (s_ab),
    .b_i (c_i),
    .s_o (s_o),
    .c_o (c_abc)
  );

  // The two half-adder carries can never both be 1, so OR is enough.
  assign c_o = c_ab | c_abc;

endmodule

// File: rtl/serial_adder.sv
// serial_adder -- digit-serial adder, DIGIT bits per clock, LSB slice first.
//
// Parameters:
//   WIDTH : operand / sum width in bits (2..64)
//   DIGIT : bits added per cycle, must divide WIDTH
//
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : request an addition (sampled in IDLE and DONE)
//   in1, in2 : addends
//   cin      : carry in
//   busy     : 1 while the addition is running
//   done     : 1-cycle pulse, result valid
//   sum      : result, held until the next result is produced
//   carry    : unsigned carry out of the MSB
//   overflow : signed overflow (carry into MSB xor carry out of MSB)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | adding one DIGIT-bit slice per clock, N = WIDTH/DIGIT cycles
// DONE  | result valid (done=1); start here chains straight into RUN
module serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = $clog2(N) + 1;

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               c_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [WIDTH-1:0]   a_d;
  logic [WIDTH-1:0]   b_d;
  logic [DIGIT:0]     chain;
  logic [DIGIT-1:0]   slice_sum;

  // Slice adder: DIGIT chained full adders fed by the low slice of the
  // operand registers and the carry stored from the previous slice.
  assign chain[0] = c_q;

  for (genvar g = 0; g < DIGIT; g++) begin : g_fa
    full_adder u_fa (
      .a_i (a_q[g]),
      .b_i (b_q[g]),
      .c_i (chain[g]),
      .s_o (slice_sum[g]),
      .c_o (chain[g+1])
    );
  end

  // a_q doubles as the partial-sum register: each slice of sum enters at
  // the top while the consumed addend slice falls off the bottom, so after
  // N shifts a_q holds the complete result in order.
  if (DIGIT == WIDTH) begin : g_a_full
    assign a_d = slice_sum;
  end else begin : g_a_shift
    assign a_d = {slice_sum, a_q[WIDTH-1:DIGIT]};
  end

  assign b_d = b_q >> DIGIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Accept edge: capture only, arithmetic starts next edge.
            a_q     <= in1;
            b_q     <= in2;
            c_q     <= cin;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= RUN;
          end else begin
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        end

        RUN: begin
          a_q <= a_d;
          b_q <= b_d;
          c_q <= chain[DIGIT];
          if (cnt_q == CNT_W'(N - 1)) begin
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            sum      <= a_d;
            carry    <= chain[DIGIT];
            // The last slice holds the MSB: its carry in is chain[DIGIT-1].
            overflow <= chain[DIGIT-1] ^ chain[DIGIT];
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          cnt_q   <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: one instance with DIGIT=1 and one with DIGIT=4.
// Stimulus pushes hand-computed expectations into a per-instance queue;
// a monitor per instance pops and compares on every done pulse.
module tb_serial_adder;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       v;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic       s1_start = 1'b0;
  logic [7:0] s1_in1 = '0, s1_in2 = '0;
  logic       s1_cin = 1'b0;
  logic       s1_busy, s1_done, s1_carry, s1_ovf;
  logic [7:0] s1_sum;

  logic       s4_start = 1'b0;
  logic [7:0] s4_in1 = '0, s4_in2 = '0;
  logic       s4_cin = 1'b0;
  logic       s4_busy, s4_done, s4_carry, s4_ovf;
  logic [7:0] s4_sum;

  exp_t q1[$];
  exp_t q4[$];

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (s1_start),
    .in1      (s1_in1),
    .in2      (s1_in2),
    .cin      (s1_cin),
    .busy     (s1_busy),
    .done     (s1_done),
    .sum      (s1_sum),
    .carry    (s1_carry),
    .overflow (s1_ovf)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (s4_start),
    .in1      (s4_in1),
    .in2      (s4_in2),
    .cin      (s4_cin),
    .busy     (s4_busy),
    .done     (s4_done),
    .sum      (s4_sum),
    .carry    (s4_carry),
    .overflow (s4_ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitors: latency counts edges from the accept edge through the edge
  // that raises done, so N+1 edges (9 for DIGIT=1, 3 for DIGIT=4).
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && s1_done === 1'b1) begin
      if (q1.size() == 0) begin
        check("d1 unexpected done", 1, 0);
      end else begin
        e = q1.pop_front();
        check("d1 sum", s1_sum, e.s);
        check("d1 carry", s1_carry, e.c);
        check("d1 overflow", s1_ovf, e.v);
        check("d1 busy at done", s1_busy, 0);
        check("d1 latency", cyc - e.acc + 1, 9);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && s4_done === 1'b1) begin
      if (q4.size() == 0) begin
        check("d4 unexpected done", 1, 0);
      end else begin
        e = q4.pop_front();
        check("d4 sum", s4_sum, e.s);
        check("d4 carry", s4_carry, e.c);
        check("d4 overflow", s4_ovf, e.v);
        check("d4 latency", cyc - e.acc + 1, 3);
      end
    end
  end

  // Drive one start pulse; optionally push the expected result. Inputs are
  // scrambled right after the accept edge to show operands were captured.
  task automatic issue(input bit w4, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec, input logic ev, input bit push);
    exp_t e;
    @(negedge clk);
    if (w4) begin s4_start = 1'b1; s4_in1 = a; s4_in2 = b; s4_cin = c; end
    else    begin s1_start = 1'b1; s1_in1 = a; s1_in2 = b; s1_cin = c; end
    @(posedge clk);
    #1;
    e.s = es; e.c = ec; e.v = ev; e.acc = cyc;
    if (push) begin
      if (w4) q4.push_back(e);
      else    q1.push_back(e);
    end
    @(negedge clk);
    if (w4) begin s4_start = 1'b0; s4_in1 = ~a; s4_in2 = ~b; s4_cin = ~c; end
    else    begin s1_start = 1'b0; s1_in1 = ~a; s1_in2 = ~b; s1_cin = ~c; end
  endtask

  // Wait (bounded) for the monitor to consume the expectation, then check
  // that done was a single pulse and the result is held in IDLE.
  task automatic drain(input bit w4, input logic [7:0] es);
    int k;
    k = 0;
    while ((w4 ? q4.size() : q1.size()) != 0 && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (k >= 40) begin
      check(w4 ? "d4 done timeout" : "d1 done timeout", 1, 0);
    end else begin
      @(negedge clk);
      #1;
      check(w4 ? "d4 done one cycle" : "d1 done one cycle", w4 ? s4_done : s1_done, 0);
      check(w4 ? "d4 busy idle" : "d1 busy idle", w4 ? s4_busy : s1_busy, 0);
      check(w4 ? "d4 sum hold" : "d1 sum hold", w4 ? s4_sum : s1_sum, es);
    end
  endtask

  task automatic op(input bit w4, input logic [7:0] a, input logic [7:0] b, input logic c,
                    input logic [7:0] es, input logic ec, input logic ev);
    issue(w4, a, b, c, es, ec, ev, 1'b1);
    drain(w4, es);
  endtask

  initial begin
    logic [7:0] ba[3];
    logic [7:0] bb[3];
    logic       bc[3];
    logic [7:0] bs[3];
    logic       bco[3];
    int         dc[3];
    int         k;
    exp_t       e;

    rst_n = 1'b0;
    #7;
    check("reset busy", s1_busy, 0);
    check("reset done", s1_done, 0);
    check("reset sum", s1_sum, 0);
    check("reset carry", s1_carry, 0);
    check("reset overflow", s1_ovf, 0);
    check("reset d4 busy", s4_busy, 0);
    #5;
    rst_n = 1'b1;

    // DIGIT=1 directed vectors
    op(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    op(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op(1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op(1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    op(1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
    op(1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    op(1'b0, 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1);

    // DIGIT=4 directed vectors
    op(1'b1, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
    op(1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op(1'b1, 8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0, 1'b0);

    // start and new operands during RUN must be ignored
    issue(1'b0, 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    s1_start = 1'b1; s1_in1 = 8'hFF; s1_in2 = 8'hFF; s1_cin = 1'b1;
    @(negedge clk);
    s1_start = 1'b0;
    drain(1'b0, 8'h33);

    // reset during the 4th RUN cycle aborts; no done may follow
    issue(1'b0, 8'h55, 8'h0F, 1'b0, 8'h64, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst busy", s1_busy, 0);
    check("async rst done", s1_done, 0);
    check("async rst sum", s1_sum, 0);
    check("async rst carry", s1_carry, 0);
    check("async rst overflow", s1_ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post rst busy", s1_busy, 0);
    op(1'b0, 8'h55, 8'h0F, 1'b0, 8'h64, 1'b0, 1'b0);

    // back-to-back with start held high through DONE
    ba[0] = 8'h01; bb[0] = 8'h02; bc[0] = 1'b0; bs[0] = 8'h03; bco[0] = 1'b0;
    ba[1] = 8'h80; bb[1] = 8'h7F; bc[1] = 1'b1; bs[1] = 8'h00; bco[1] = 1'b1;
    ba[2] = 8'hC0; bb[2] = 8'hC0; bc[2] = 1'b0; bs[2] = 8'h80; bco[2] = 1'b1;
    @(negedge clk);
    s1_start = 1'b1; s1_in1 = ba[0]; s1_in2 = bb[0]; s1_cin = bc[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      e.s = bs[i]; e.c = bco[i]; e.v = 1'b0; e.acc = cyc;
      q1.push_back(e);
      @(negedge clk);
      if (i < 2) begin
        s1_in1 = ba[i+1]; s1_in2 = bb[i+1]; s1_cin = bc[i+1];
      end else begin
        s1_start = 1'b0;
      end
      k = 0;
      while (s1_done !== 1'b1 && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (s1_done !== 1'b1) check("b2b done timeout", 1, 0);
      dc[i] = cyc;
    end
    check("b2b period 1", dc[1] - dc[0], 9);
    check("b2b period 2", dc[2] - dc[1], 9);

    repeat (15) @(negedge clk);
    check("d1 queue empty", q1.size(), 0);
    check("d4 queue empty", q4.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
